// File: rtl/intr_entry_seq_pkg.sv
// Shared definitions for the interrupt entry/exit sequencer: exception codes,
// SPR numbers, MSR bit masks ([0:31] bit order) and the sequencer state encoding.
package intr_entry_seq_pkg;

    localparam int ExcepCode_WIDTH = 4;

    localparam logic [ExcepCode_WIDTH-1:0] ExcepCode_NONE  = 4'd0;
    localparam logic [ExcepCode_WIDTH-1:0] ExcepCode_SC    = 4'd1;
    localparam logic [ExcepCode_WIDTH-1:0] ExcepCode_DSI   = 4'd2;
    localparam logic [ExcepCode_WIDTH-1:0] ExcepCode_DMISS = 4'd3;
    localparam logic [ExcepCode_WIDTH-1:0] ExcepCode_ISI   = 4'd4;
    localparam logic [ExcepCode_WIDTH-1:0] ExcepCode_DEV0  = 4'd5;
    localparam logic [ExcepCode_WIDTH-1:0] ExcepCode_PROG  = 4'd6;
    localparam logic [ExcepCode_WIDTH-1:0] ExcepCode_EXT   = 4'd7;

    localparam logic [9:0] SPRN_SRR0 = 10'd26;
    localparam logic [9:0] SPRN_SRR1 = 10'd27;
    localparam logic [9:0] SPRN_DEAR = 10'd61;

    localparam logic [31:0] MSR_EE = 32'h0000_8000;
    localparam logic [31:0] MSR_PR = 32'h0000_4000;
    localparam logic [31:0] MSR_IS = 32'h0000_0020;
    localparam logic [31:0] MSR_DS = 32'h0000_0010;

    localparam int IES_W = 4;
    localparam logic [IES_W-1:0] IES_IDLE  = 4'd0;
    localparam logic [IES_W-1:0] IES_FLUSH = 4'd1;
    localparam logic [IES_W-1:0] IES_SAVE0 = 4'd2;
    localparam logic [IES_W-1:0] IES_SAVE1 = 4'd3;
    localparam logic [IES_W-1:0] IES_SAVED = 4'd4;
    localparam logic [IES_W-1:0] IES_MSRUP = 4'd5;
    localparam logic [IES_W-1:0] IES_REDIR = 4'd6;
    localparam logic [IES_W-1:0] IES_RFI0  = 4'd7;
    localparam logic [IES_W-1:0] IES_RFI1  = 4'd8;

    function automatic logic is_dear_code(input logic [ExcepCode_WIDTH-1:0] code);
        return (code == ExcepCode_DSI) || (code == ExcepCode_DMISS);
    endfunction

endpackage

// File: rtl/intr_entry_seq.sv
// Interrupt entry/exit sequencer: drains the pipe, saves SRR0/SRR1 (and DEAR when
// INTR_DEAR_SAVE_EN is defined), masks MSR, redirects fetch; also sequences rfi.
module intr_entry_seq
    import intr_entry_seq_pkg::*;
#(
    parameter logic [31:0] MSR_CLR_MASK = 32'h0000_C030,
    parameter logic [31:0] SC_PC_INC    = 32'd4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ExcepCode_WIDTH-1:0] excep_code,
    input  logic [31:0]                intr_entry_addr,
    input  logic [31:0]                excep_pc,
    input  logic [31:0]                excep_dear,
    input  logic [31:0]                msr_in,
    input  logic                       pipe_empty,
    input  logic                       rfi_req,
    input  logic [31:0]                srr0_in,
    input  logic [31:0]                srr1_in,
    output logic                       flush,
    output logic                       busy,
    output logic                       spr_wr,
    output logic [9:0]                 spr_addr,
    output logic [31:0]                spr_wd,
    output logic                       msr_wr,
    output logic [31:0]                msr_wd,
    output logic                       npc_wr,
    output logic [31:0]                npc,
    output logic                       ack,
    output logic                       rfi_done
);

    logic [IES_W-1:0]           r_state;
    logic [IES_W-1:0]           w_next;
    logic [ExcepCode_WIDTH-1:0] r_code;
    logic [31:0]                r_pc;
    logic [31:0]                r_msr;
    logic [31:0]                r_vec;
    logic [31:0]                r_srr0;
    logic [31:0]                r_srr1;
    logic                       w_exc_pending;
    logic [31:0]                w_srr0_wd;

`ifdef INTR_DEAR_SAVE_EN
    logic [31:0]                r_dear;
`else
    logic                       w_unused_dear;
    assign w_unused_dear = ^excep_dear;
`endif

    assign w_exc_pending = (excep_code != ExcepCode_NONE);
    assign w_srr0_wd     = r_pc + ((r_code == ExcepCode_SC) ? SC_PC_INC : 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IES_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Context is captured only on the IDLE exit; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (r_state == IES_IDLE) begin
            if (w_exc_pending) begin
                r_code <= excep_code;
                r_pc   <= excep_pc;
                r_msr  <= msr_in;
                r_vec  <= intr_entry_addr;
`ifdef INTR_DEAR_SAVE_EN
                r_dear <= excep_dear;
`endif
            end else if (rfi_req) begin
                r_srr0 <= srr0_in;
                r_srr1 <= srr1_in;
            end
        end
    end

    always_comb begin
        w_next = IES_IDLE;
        case (r_state)
            IES_IDLE: begin
                if (w_exc_pending) begin
                    w_next = IES_FLUSH;
                end else if (rfi_req) begin
                    w_next = IES_RFI0;
                end
            end
            IES_FLUSH: w_next = pipe_empty ? IES_SAVE0 : IES_FLUSH;
            IES_SAVE0: w_next = IES_SAVE1;
`ifdef INTR_DEAR_SAVE_EN
            IES_SAVE1: w_next = is_dear_code(r_code) ? IES_SAVED : IES_MSRUP;
            IES_SAVED: w_next = IES_MSRUP;
`else
            IES_SAVE1: w_next = IES_MSRUP;
`endif
            IES_MSRUP: w_next = IES_REDIR;
            IES_REDIR: w_next = IES_IDLE;
            IES_RFI0:  w_next = IES_RFI1;
            IES_RFI1:  w_next = IES_IDLE;
            default:   w_next = IES_IDLE;
        endcase
    end

    // Outputs decode from state and captured context only, so a reset drops them at once.
    always_comb begin
        flush    = 1'b0;
        busy     = 1'b0;
        spr_wr   = 1'b0;
        spr_addr = 10'd0;
        spr_wd   = 32'd0;
        msr_wr   = 1'b0;
        msr_wd   = 32'd0;
        npc_wr   = 1'b0;
        npc      = 32'd0;
        ack      = 1'b0;
        rfi_done = 1'b0;
        case (r_state)
            IES_FLUSH: begin
                flush = 1'b1;
                busy  = 1'b1;
            end
            IES_SAVE0: begin
                flush    = 1'b1;
                busy     = 1'b1;
                spr_wr   = 1'b1;
                spr_addr = SPRN_SRR0;
                spr_wd   = w_srr0_wd;
            end
            IES_SAVE1: begin
                flush    = 1'b1;
                busy     = 1'b1;
                spr_wr   = 1'b1;
                spr_addr = SPRN_SRR1;
                spr_wd   = r_msr;
            end
`ifdef INTR_DEAR_SAVE_EN
            IES_SAVED: begin
                flush    = 1'b1;
                busy     = 1'b1;
                spr_wr   = 1'b1;
                spr_addr = SPRN_DEAR;
                spr_wd   = r_dear;
            end
`endif
            IES_MSRUP: begin
                flush  = 1'b1;
                busy   = 1'b1;
                msr_wr = 1'b1;
                msr_wd = r_msr & ~MSR_CLR_MASK;
            end
            IES_REDIR: begin
                flush  = 1'b1;
                busy   = 1'b1;
                npc_wr = 1'b1;
                npc    = r_vec;
                ack    = 1'b1;
            end
            IES_RFI0: begin
                busy   = 1'b1;
                msr_wr = 1'b1;
                msr_wd = r_srr1;
            end
            IES_RFI1: begin
                busy     = 1'b1;
                npc_wr   = 1'b1;
                npc      = r_srr0;
                rfi_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
